// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with a direct-select mode
// and an auto-scan mode that walks every channel with a programmable dwell.
module mux_scan #(
  parameter  int N_CH  = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  output logic              wrap
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam logic [SELW-1:0] LAST_CH    = SELW'(N_CH - 1);
  localparam logic [7:0]      LAST_DWELL = 8'(DWELL - 1);

  state_t          state_q;
  state_t          state_d;
  logic [SELW-1:0] ch_cnt;
  logic [SELW-1:0] ch_d;
  logic [7:0]      dwell;
  logic [7:0]      dwell_d;
  logic [W-1:0]    out_d;
  logic [SELW-1:0] out_ch_d;
  logic            valid_d;
  logic            wrap_d;
  logic            entering;
  logic [SELW-1:0] eff_ch;
  logic [7:0]      eff_dwell;
  logic [SELW-1:0] pick;
  logic [W-1:0]    pick_data;
  logic            pick_hit;

  // Next state follows en/mode directly; entering SCAN restarts both counters
  // so the very first sample of a scan is channel 0.
  always_comb begin
    state_d = IDLE;
    if (en) begin
      state_d = mode ? SCAN : DIRECT;
    end
    entering  = (state_d == SCAN) && (state_q != SCAN);
    eff_ch    = entering ? '0 : ch_cnt;
    eff_dwell = entering ? '0 : dwell;
  end

  // Channel picker; pick_hit stays low for select values beyond the last channel.
  always_comb begin
    pick      = (state_d == SCAN) ? eff_ch : sel;
    pick_data = '0;
    pick_hit  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (SELW'(k) == pick) begin
        pick_data = in[k*W +: W];
        pick_hit  = 1'b1;
      end
    end
  end

  // Output and counter updates follow the rule of the state being entered.
  always_comb begin
    out_d    = out;
    out_ch_d = out_ch;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    ch_d     = ch_cnt;
    dwell_d  = dwell;
    case (state_d)
      DIRECT: begin
        out_d    = pick_hit ? pick_data : '0;
        out_ch_d = sel;
        valid_d  = pick_hit;
      end
      SCAN: begin
        out_d    = pick_data;
        out_ch_d = eff_ch;
        valid_d  = 1'b1;
        wrap_d   = !entering && (eff_ch == '0) && (eff_dwell == '0);
        if (eff_dwell == LAST_DWELL) begin
          dwell_d = '0;
          ch_d    = (eff_ch == LAST_CH) ? '0 : eff_ch + SELW'(1);
        end else begin
          dwell_d = eff_dwell + 8'd1;
          ch_d    = eff_ch;
        end
      end
      default: begin
        out_d = out;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_cnt    <= '0;
      dwell     <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt    <= ch_d;
      dwell     <= dwell_d;
      out       <= out_d;
      out_ch    <= out_ch_d;
      out_valid <= valid_d;
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: self-checking bench for mux_scan using two configurations,
// a 4x1-bit instance (dwell 3) and a 5x8-bit instance (dwell 2).
module tb_mux_scan;

  localparam int B_N     = 5;
  localparam int B_DWELL = 2;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] din;
    logic       exp_out;
  } vec_t;

  logic        clk;
  logic        rst_n;

  logic [3:0]  a_in;
  logic        a_en;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [0:0]  a_out;
  logic [1:0]  a_out_ch;
  logic        a_out_valid;
  logic        a_wrap;

  logic [39:0] b_in;
  logic        b_en;
  logic        b_mode;
  logic [2:0]  b_sel;
  logic [7:0]  b_out;
  logic [2:0]  b_out_ch;
  logic        b_out_valid;
  logic        b_wrap;

  int tests_run;
  int tests_failed;

  int m_out;
  int m_ch;
  int m_valid;
  int m_wrap;
  int m_k;
  bit m_scanning;

  vec_t       vecs [64];
  logic [3:0] pat;
  int         exp_ch;

  mux_scan #(.N_CH(4), .W(1), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .en(a_en), .mode(a_mode), .sel(a_sel),
    .out(a_out), .out_ch(a_out_ch), .out_valid(a_out_valid), .wrap(a_wrap)
  );

  mux_scan #(.N_CH(B_N), .W(8), .DWELL(B_DWELL)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .en(b_en), .mode(b_mode), .sel(b_sel),
    .out(b_out), .out_ch(b_out_ch), .out_valid(b_out_valid), .wrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference for instance b: scan position is derived from the number of
  // cycles spent in scan since entry, not from any counter pair.
  task automatic model_step_b();
    if (!b_en) begin
      m_valid    = 0;
      m_wrap     = 0;
      m_scanning = 0;
    end else if (!b_mode) begin
      m_scanning = 0;
      m_wrap     = 0;
      m_ch       = int'(b_sel);
      if (m_ch < B_N) begin
        m_out   = int'(b_in[m_ch*8 +: 8]);
        m_valid = 1;
      end else begin
        m_out   = 0;
        m_valid = 0;
      end
    end else begin
      if (!m_scanning) begin
        m_scanning = 1;
        m_k        = 0;
      end else begin
        m_k++;
      end
      m_ch    = (m_k / B_DWELL) % B_N;
      m_out   = int'(b_in[m_ch*8 +: 8]);
      m_valid = 1;
      m_wrap  = (m_k > 0 && (m_k % (B_DWELL * B_N)) == 0) ? 1 : 0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pat          = 4'b1010;

    for (int i = 0; i < 64; i++) begin
      logic [5:0] iv;
      iv = 6'(i);
      vecs[i].sel     = iv[5:4];
      vecs[i].din     = iv[3:0];
      vecs[i].exp_out = vecs[i].din[vecs[i].sel];
    end

    rst_n  = 1'b0;
    a_in   = '0; a_en = 1'b0; a_mode = 1'b0; a_sel = '0;
    b_in   = '0; b_en = 1'b0; b_mode = 1'b0; b_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: everything stays zero.
    for (int c = 0; c < 5; c++) begin
      tick();
      check_output("idle_a", 32'({a_out, a_out_ch, a_out_valid, a_wrap}), 32'h0);
      check_output("idle_b", 32'({b_out, b_out_ch, b_out_valid, b_wrap}), 32'h0);
    end

    // Direct mode, every sel/in combination on the 4x1 instance.
    a_en   = 1'b1;
    a_mode = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a_sel = vecs[i].sel;
      a_in  = vecs[i].din;
      tick();
      check_output("direct_out",   32'(a_out),       32'(vecs[i].exp_out));
      check_output("direct_ch",    32'(a_out_ch),    32'(vecs[i].sel));
      check_output("direct_valid", 32'(a_out_valid), 32'h1);
      check_output("direct_wrap",  32'(a_wrap),      32'h0);
    end

    // Illegal then legal select on the 5-channel instance.
    b_en   = 1'b1;
    b_mode = 1'b0;
    b_in   = {8'hA5, 32'($urandom())};
    b_sel  = 3'd6;
    tick();
    check_output("illegal_out",   32'(b_out),       32'h0);
    check_output("illegal_valid", 32'(b_out_valid), 32'h0);
    check_output("illegal_ch",    32'(b_out_ch),    32'h6);
    b_sel = 3'd4;
    tick();
    check_output("legal_out",   32'(b_out),       32'hA5);
    check_output("legal_valid", 32'(b_out_valid), 32'h1);
    check_output("legal_ch",    32'(b_out_ch),    32'h4);
    b_en = 1'b0;

    // Scan with dwell 3 through a full wrap and on to channel 2, dwell 1.
    a_in   = pat;
    a_mode = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_ch = (c / 3) % 4;
      check_output("scan_ch",    32'(a_out_ch),    32'(exp_ch));
      check_output("scan_out",   32'(a_out),       32'(pat[exp_ch]));
      check_output("scan_valid", 32'(a_out_valid), 32'h1);
      check_output("scan_wrap",  32'(a_wrap),      (c == 12) ? 32'h1 : 32'h0);
    end

    // Mid-dwell switch to direct, then back to scan restarting at channel 0.
    a_mode = 1'b0;
    a_sel  = 2'd1;
    tick();
    check_output("switch_ch",   32'(a_out_ch), 32'h1);
    check_output("switch_out",  32'(a_out),    32'h1);
    check_output("switch_wrap", 32'(a_wrap),   32'h0);
    a_mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_ch = (c / 3) % 4;
      check_output("rescan_ch",   32'(a_out_ch), 32'(exp_ch));
      check_output("rescan_out",  32'(a_out),    32'(pat[exp_ch]));
      check_output("rescan_wrap", 32'(a_wrap),   32'h0);
    end

    // Asynchronous reset between edges while showing channel 3.
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_a", 32'({a_out, a_out_ch, a_out_valid, a_wrap}), 32'h0);
    check_output("async_reset_b", 32'({b_out, b_out_ch, b_out_valid, b_wrap}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_output("post_reset_ch",    32'(a_out_ch),    32'h0);
    check_output("post_reset_out",   32'(a_out),       32'h0);
    check_output("post_reset_valid", 32'(a_out_valid), 32'h1);
    check_output("post_reset_wrap",  32'(a_wrap),      32'h0);
    tick();
    check_output("post_reset_dwell", 32'(a_out_ch),    32'h0);

    // Randomised traffic on the 5x8 instance against the reference model.
    a_en       = 1'b0;
    m_out      = 0;
    m_ch       = 0;
    m_valid    = 0;
    m_wrap     = 0;
    m_k        = 0;
    m_scanning = 0;
    for (int c = 0; c < 400; c++) begin
      b_en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) b_mode = ~b_mode;
      b_sel = 3'($urandom_range(0, 7));
      b_in  = 40'({$urandom(), $urandom()});
      model_step_b();
      tick();
      check_output("rand_out",   32'(b_out),       32'(m_out));
      check_output("rand_ch",    32'(b_out_ch),    32'(m_ch));
      check_output("rand_valid", 32'(b_out_valid), 32'(m_valid));
      check_output("rand_wrap",  32'(b_wrap),      32'(m_wrap));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
